decoder_nx_seq: RTL and testbench
=================================

# decoder_nx_seq

Parametrised, registered N-to-2^N one-hot decoder with enable, load strobe and an auto-sweep mode. It generalises the combinational 2-to-4 decoder into a sequential block: select width and output polarity are parameters, and outputs are registered with a valid flag. A built-in sweep counter walks the active output through all 2^N positions with a programmable dwell, for channel scanning and strobe generation.

## Interface
- SEL_W, 2, select width in bits; legal range 1..6.
- OUT_W, 2**SEL_W, output width; a derived localparam that cannot be overridden.
- ACTIVE_LOW, 0, 0: the asserted output bit is 1, others 0. 1: the asserted output bit is 0, others 1.
- DWELL, 1, cycles each output stays asserted in sweep mode; legal range 1..255.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; when low, outputs go inactive.
- mode  in  1  0 = direct decode, 1 = sweep.
- load  in  1  direct mode: sample S this cycle.
- S  in  SEL_W  select value; in sweep mode, the start index.
- Y  out  OUT_W  registered decoded output.
- Y_valid  out  1  Y holds a decoded value.
- wrap  out  1  one-cycle pulse when the sweep index wraps from OUT_W-1 to 0.
- busy  out  1  high while in the SWEEP state.

## Operation
- Inactive pattern: all 0 when ACTIVE_LOW=0; all 1 when ACTIVE_LOW=1. "onehot(i)" means bit i asserted in the configured polarity.
- Internal state:
  - FSM states IDLE, DIRECT, SWEEP.
  - Index register idx, SEL_W bits.
  - Dwell counter dcnt, 8 bits.
- IDLE:
  - Y = inactive, Y_valid = 0, busy = 0.
  - en=1, mode=0 → DIRECT. If load=1 in the same cycle, S is captured.
  - en=1, mode=1 → SWEEP. idx <= S, dcnt <= 0.
- DIRECT:
  - On load=1: idx <= S. Next cycle Y = onehot(S), Y_valid = 1.
  - Without load, Y and idx hold. Y_valid stays 0 until the first load after entry.
  - mode=1 → SWEEP. idx <= S (current S), dcnt <= 0.
- SWEEP:
  - Y = onehot(idx), Y_valid = 1, busy = 1.
  - dcnt increments each cycle. When dcnt == DWELL-1: dcnt <= 0 and idx <= idx+1 (mod OUT_W).
  - When idx steps from OUT_W-1 to 0, wrap pulses for the cycle in which idx becomes 0.
  - load is ignored. mode=0 → DIRECT; Y and idx hold their last value and Y_valid stays 1.
- en=0 from any state: next cycle IDLE, Y = inactive, Y_valid = 0, wrap = 0. idx and dcnt are cleared.
- Priority: rst_n > en > mode > load.
- Exactly one bit of Y is asserted whenever Y_valid=1; none when Y_valid=0.

## Timing
- Reset (asynchronous, immediate on rst_n low):
  - State = IDLE.
  - Y = inactive pattern, Y_valid = 0, wrap = 0, busy = 0.
  - idx = 0, dcnt = 0.
  - Release is synchronous to the next clk edge.
- Direct latency: 1 cycle from the load edge to Y/Y_valid.
- Sweep latency: Y = onehot(S) appears 1 cycle after the edge where en=1 and mode=1 are sampled. Each index is then held for exactly DWELL cycles.
- DWELL=1: idx advances every cycle. With SEL_W=1, Y toggles between positions 0 and 1.
- Sweep start at S=OUT_W-1: the first step wraps, so wrap pulses after DWELL cycles.
- Reset mid-sweep: outputs go inactive immediately. After release the block re-enters SWEEP from the current S, not from the old idx.
- en toggled low for a single cycle: one IDLE cycle with inactive Y, then re-entry per the IDLE rules.
- A load and a mode change in the same cycle: the mode change wins and load is ignored.

## Test plan
- Reset values, with SEL_W=2, ACTIVE_LOW=0: hold rst_n=0 → Y=0000, Y_valid=0, wrap=0, busy=0. Repeat with ACTIVE_LOW=1 → Y=1111.
- Direct decode, with en=1, mode=0: load S=00,01,10,11 on consecutive cycles → Y=0001,0010,0100,1000, each one cycle after its load, Y_valid=1. Dropping load holds Y=1000.
- Sweep with DWELL=2, S=10: set en=1, mode=1 → Y sequence 0100,0100,1000,1000,0001,0001. wrap pulses on the first 0001 cycle; busy=1 throughout.
- Width generalisation, with SEL_W=3, ACTIVE_LOW=1: load S=101 → Y=11011111. Sweep with DWELL=1 from S=110 → 10111111, 01111111, 11111110 with wrap.
- Enable drop mid-sweep (en=0 for one cycle): → Y=inactive, Y_valid=0 for that cycle. Sweep restarts from the current S.
- Async reset mid-sweep: assert rst_n=0 between clock edges → Y goes inactive without waiting for clk. After release, a mode=0 load of S=11 gives Y=1000.

Source files
------------

// File: rtl/decoder_nx_seq.sv
// Registered N-to-2^N one-hot decoder with enable, load strobe and an auto-sweep mode.
// A dwell counter holds each swept position for DWELL cycles and flags the wrap to index 0.
module decoder_nx_seq #(
    parameter int SEL_W      = 2,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int DWELL      = 1,
    localparam int OUT_W     = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [SEL_W-1:0] S,
    output logic [OUT_W-1:0] Y,
    output logic             Y_valid,
    output logic             wrap,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SWEEP  = 2'd2
    } state_t;

    localparam logic [OUT_W-1:0] Y_INACTIVE = {OUT_W{ACTIVE_LOW}};
    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_W - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [7:0]         dcnt_q, dcnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               wrap_q, wrap_d;
    logic               busy_q, busy_d;
    logic [SEL_W-1:0]   idx_step;

    // XOR with the inactive pattern flips the whole vector for active-low outputs.
    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v ^ Y_INACTIVE;
    endfunction

    assign idx_step = idx_q + SEL_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dcnt_d    = dcnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        wrap_d    = 1'b0;
        busy_d    = 1'b0;

        if (!en) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            dcnt_d    = '0;
            y_d       = Y_INACTIVE;
            y_valid_d = 1'b0;
        end else if (mode && state_q != ST_SWEEP) begin
            // Sweep entry starts from the present S; a simultaneous load is ignored.
            state_d   = ST_SWEEP;
            idx_d     = S;
            dcnt_d    = '0;
            y_d       = onehot(S);
            y_valid_d = 1'b1;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DIRECT: begin
                    state_d = ST_DIRECT;
                    dcnt_d  = '0;
                    if (load) begin
                        idx_d     = S;
                        y_d       = onehot(S);
                        y_valid_d = 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (mode) begin
                        busy_d    = 1'b1;
                        y_valid_d = 1'b1;
                        if (dcnt_q == DWELL_LAST) begin
                            dcnt_d = '0;
                            idx_d  = idx_step;
                            wrap_d = (idx_q == IDX_LAST);
                        end else begin
                            dcnt_d = dcnt_q + 8'd1;
                        end
                        y_d = onehot(idx_d);
                    end else begin
                        // Leaving sweep keeps the last position visible and valid.
                        state_d = ST_DIRECT;
                        dcnt_d  = '0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    dcnt_d    = '0;
                    y_d       = Y_INACTIVE;
                    y_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            dcnt_q    <= '0;
            y_q       <= Y_INACTIVE;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dcnt_q    <= dcnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            wrap_q    <= wrap_d;
            busy_q    <= busy_d;
        end
    end

    assign Y       = y_q;
    assign Y_valid = y_valid_q;
    assign wrap    = wrap_q;
    assign busy    = busy_q;

`ifndef SYNTHESIS
    a_inactive_when_invalid : assert property (@(posedge clk) disable iff (!rst_n)
        y_valid_q || (y_q == Y_INACTIVE));
    a_onehot_when_valid : assert property (@(posedge clk) disable iff (!rst_n)
        !y_valid_q || $onehot(y_q ^ Y_INACTIVE));
`endif

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Scoreboard bench for decoder_nx_seq: three configurations driven from shared inputs,
// expectations from a position/elapsed-time reference model, checked by a separate monitor.
module tb_decoder_nx_seq;

    localparam int NDUT = 3;
    localparam int PH_IDLE = 0, PH_DIRECT = 1, PH_SWEEP = 2;

    typedef struct packed {
        int                  cyc;
        logic [2:0][7:0]     y;
        logic [2:0]          v;
        logic [2:0]          w;
        logic [2:0]          b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, load;
    logic [2:0] s;

    logic [3:0] y_a;  logic yv_a, wrap_a, busy_a;
    logic [7:0] y_b;  logic yv_b, wrap_b, busy_b;
    logic [1:0] y_c;  logic yv_c, wrap_c, busy_c;

    int   cycle = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q[$];

    const int outw[NDUT] = '{4, 8, 2};
    const bit al[NDUT]   = '{1'b0, 1'b1, 1'b0};
    const int dw[NDUT]   = '{2, 1, 3};
    int phase[NDUT];
    int idx[NDUT];
    int start[NDUT];
    int elapsed[NDUT];
    bit valid[NDUT];

    decoder_nx_seq #(.SEL_W(2), .ACTIVE_LOW(1'b0), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .S(s[1:0]),
        .Y(y_a), .Y_valid(yv_a), .wrap(wrap_a), .busy(busy_a));

    decoder_nx_seq #(.SEL_W(3), .ACTIVE_LOW(1'b1), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .S(s),
        .Y(y_b), .Y_valid(yv_b), .wrap(wrap_b), .busy(busy_b));

    decoder_nx_seq #(.SEL_W(1), .ACTIVE_LOW(1'b0), .DWELL(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .S(s[0:0]),
        .Y(y_c), .Y_valid(yv_c), .wrap(wrap_c), .busy(busy_c));

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] mk_y(int k, int pos);
        logic [7:0] v;
        logic [7:0] mask;
        v    = 8'h00;
        mask = 8'((1 << outw[k]) - 1);
        if (pos >= 0) v[pos] = 1'b1;
        if (al[k]) v = ~v;
        return v & mask;
    endfunction

    function automatic exp_t inactive_exp(int c);
        exp_t x;
        x.cyc = c;
        for (int k = 0; k < NDUT; k++) begin
            x.y[k] = mk_y(k, -1);
            x.v[k] = 1'b0;
            x.w[k] = 1'b0;
            x.b[k] = 1'b0;
        end
        return x;
    endfunction

    // Sweep position is start + elapsed/DWELL, so the model never tracks a dwell counter.
    task automatic model_step(input int k, input bit e, input bit m, input bit l, input int sv,
                              output int pos, output bit v, output bit w, output bit b);
        pos = -1; v = 1'b0; w = 1'b0; b = 1'b0;
        if (!e) begin
            phase[k] = PH_IDLE;
            idx[k]   = 0;
            valid[k] = 1'b0;
        end else if (phase[k] == PH_SWEEP) begin
            if (m) begin
                elapsed[k]++;
                idx[k] = (start[k] + elapsed[k] / dw[k]) % outw[k];
                pos = idx[k]; v = 1'b1; b = 1'b1;
                w = (elapsed[k] % dw[k] == 0) && (idx[k] == 0);
            end else begin
                phase[k] = PH_DIRECT;
                valid[k] = 1'b1;
                pos = idx[k]; v = 1'b1;
            end
        end else if (m) begin
            phase[k]   = PH_SWEEP;
            start[k]   = sv;
            elapsed[k] = 0;
            idx[k]     = sv;
            pos = sv; v = 1'b1; b = 1'b1;
        end else begin
            if (phase[k] == PH_IDLE) valid[k] = 1'b0;
            phase[k] = PH_DIRECT;
            if (l) begin
                idx[k]   = sv;
                valid[k] = 1'b1;
            end
            v   = valid[k];
            pos = valid[k] ? idx[k] : -1;
        end
    endtask

    task automatic apply_stimulus(input bit e, input bit m, input bit l, input logic [2:0] sv);
        exp_t x;
        int   pos;
        bit   v, w, b;
        en = e; mode = m; load = l; s = sv;
        x.cyc = cycle + 1;
        for (int k = 0; k < NDUT; k++) begin
            model_step(k, e, m, l, int'(sv) % outw[k], pos, v, w, b);
            x.y[k] = mk_y(k, pos);
            x.v[k] = v;
            x.w[k] = w;
            x.b[k] = b;
        end
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Called 2 time units after an edge; the expectation already queued for that edge is replaced.
    task automatic do_reset(input int n);
        exp_t x;
        if (q.size() > 0 && q[$].cyc == cycle) void'(q.pop_back());
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            phase[k] = PH_IDLE;
            idx[k]   = 0;
            valid[k] = 1'b0;
        end
        x = inactive_exp(cycle);
        q.push_back(x);
        repeat (n) begin
            @(posedge clk);
            #2;
            x.cyc = cycle;
            q.push_back(x);
        end
        rst_n = 1'b1;
    endtask

    task automatic check_output(input string nm, input int k, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("[TB] FAIL %s dut%0d cyc=%0d got=%b want=%b", nm, k, cycle, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t            x;
        logic [2:0][7:0] ay;
        logic [2:0]      av, aw, ab;
        while (q.size() > 0 && q[0].cyc < cycle) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL stale_expectation cyc=%0d got=unchecked want=cyc%0d", cycle, q[0].cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cycle) begin
            x  = q.pop_front();
            ay = {{6'b0, y_c}, y_b, {4'b0, y_a}};
            av = {yv_c, yv_b, yv_a};
            aw = {wrap_c, wrap_b, wrap_a};
            ab = {busy_c, busy_b, busy_a};
            for (int k = 0; k < NDUT; k++) begin
                check_output("Y", k, ay[k], x.y[k]);
                check_output("Y_valid", k, {7'b0, av[k]}, {7'b0, x.v[k]});
                check_output("wrap", k, {7'b0, aw[k]}, {7'b0, x.w[k]});
                check_output("busy", k, {7'b0, ab[k]}, {7'b0, x.b[k]});
            end
        end
    end

    initial begin
        bit m_r;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; s = 3'd0;
        @(posedge clk);
        #2;
        do_reset(3);

        // Direct decode of every position, then hold without load.
        apply_stimulus(1, 0, 1, 3'd0);
        apply_stimulus(1, 0, 1, 3'd1);
        apply_stimulus(1, 0, 1, 3'd2);
        apply_stimulus(1, 0, 1, 3'd3);
        apply_stimulus(1, 0, 0, 3'd3);
        apply_stimulus(1, 0, 0, 3'd0);

        // Sweep from position 2 long enough to wrap on every configuration.
        repeat (8) apply_stimulus(1, 1, 0, 3'd2);
        apply_stimulus(1, 0, 1, 3'd7);
        apply_stimulus(1, 0, 0, 3'd1);

        apply_stimulus(0, 0, 0, 3'd0);
        apply_stimulus(1, 0, 1, 3'd5);
        repeat (4) apply_stimulus(1, 1, 0, 3'd6);

        // One-cycle enable drop mid-sweep, then restart from a new S.
        apply_stimulus(0, 1, 0, 3'd3);
        repeat (3) apply_stimulus(1, 1, 0, 3'd3);

        // Asynchronous reset mid-sweep, then a direct load and a fresh sweep.
        do_reset(2);
        apply_stimulus(1, 0, 1, 3'd3);
        repeat (3) apply_stimulus(1, 1, 1, 3'd1);
        do_reset(1);
        repeat (4) apply_stimulus(1, 1, 0, 3'd1);

        m_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bit e, l;
            logic [2:0] sv;
            if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 9) == 0) m_r = ~m_r;
            e  = ($urandom_range(0, 19) != 0);
            l  = ($urandom_range(0, 1) == 1);
            sv = 3'($urandom_range(0, 7));
            apply_stimulus(e, m_r, l, sv);
        end

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL queue_drain got=%0d pending want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
